// File: rtl/tia_framebuffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tia_framebuffer: captures TIA scanlines into a 7-bit palette-index frame   |
// | store that is read by a display stage. Revision: 1.0                       |
// +----------------------------------------------------------------------------+
module tia_framebuffer #(
  parameter int H_PIXELS = 160,
  parameter int V_LINES  = 240,
  parameter int V_SKIP   = 37
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pix_valid,
  input  logic [6:0]  pix_color,
  input  logic        line_start,
  input  logic        frame_start,
  input  logic [15:0] vga_addr,
  output logic [6:0]  vga_data,
  output logic        frame_done,
  output logic        overflow
);

  localparam int c_DEPTH = H_PIXELS * V_LINES;
  localparam int c_MW    = $clog2(c_DEPTH);
  localparam int c_XW    = $clog2(H_PIXELS + 1);
  localparam int c_YW    = $clog2(V_LINES + 1);
  localparam int c_CW    = $clog2(V_SKIP + 1);

  typedef enum logic [1:0] {
    WAIT_FRAME = 2'd0,
    SKIP       = 2'd1,
    ACTIVE     = 2'd2,
    DONE       = 2'd3
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [c_XW-1:0]   r_x, w_x_nxt, w_wx;
  logic [c_YW-1:0]   r_y, w_y_nxt, w_wy;
  logic [c_CW-1:0]   r_line_cnt, w_cnt_nxt;
  logic              r_overflow, w_ovf_nxt;
  logic              r_frame_done, w_done_nxt;
  logic              w_we, w_live;
  logic [15:0]       w_wr_addr;
  logic [6:0]        r_vga_data;
  logic [6:0]        r_mem [c_DEPTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= WAIT_FRAME;
      r_x          <= '0;
      r_y          <= '0;
      r_line_cnt   <= '0;
      r_overflow   <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_x          <= w_x_nxt;
      r_y          <= w_y_nxt;
      r_line_cnt   <= w_cnt_nxt;
      r_overflow   <= w_ovf_nxt;
      r_frame_done <= w_done_nxt;
    end
  end

  // w_wx/w_wy are the pixel coordinates after any line_start this cycle,
  // so a pixel arriving with line_start lands at x=0 of the new line.
  always_comb begin
    w_state_nxt = r_state;
    w_x_nxt     = r_x;
    w_y_nxt     = r_y;
    w_cnt_nxt   = r_line_cnt;
    w_ovf_nxt   = r_overflow;
    w_done_nxt  = 1'b0;
    w_we        = 1'b0;
    w_live      = 1'b0;
    w_wx        = r_x;
    w_wy        = r_y;
    if (frame_start) begin
      w_state_nxt = SKIP;
      w_cnt_nxt   = '0;
      w_x_nxt     = '0;
      w_y_nxt     = '0;
      w_ovf_nxt   = 1'b0;
    end else begin
      unique case (r_state)
        SKIP: begin
          if (line_start) begin
            w_cnt_nxt = r_line_cnt + 1'b1;
            if (w_cnt_nxt == c_CW'(V_SKIP)) begin
              w_state_nxt = ACTIVE;
              w_x_nxt     = '0;
              w_y_nxt     = '0;
              w_wx        = '0;
              w_wy        = '0;
              w_live      = 1'b1;
            end
          end
        end
        ACTIVE: begin
          w_live = 1'b1;
          if (line_start) begin
            if (r_y == c_YW'(V_LINES - 1)) begin
              w_state_nxt = DONE;
              w_done_nxt  = 1'b1;
              w_live      = 1'b0;
            end else begin
              w_y_nxt = r_y + 1'b1;
              w_x_nxt = '0;
              w_wx    = '0;
              w_wy    = r_y + 1'b1;
            end
          end
        end
        default: begin
        end
      endcase
      if (w_live && pix_valid) begin
        if (w_wx < c_XW'(H_PIXELS)) begin
          w_we    = 1'b1;
          w_x_nxt = w_wx + 1'b1;
        end else begin
          w_ovf_nxt = 1'b1;
          w_x_nxt   = w_wx;
        end
      end
    end
  end

  generate
    if (H_PIXELS == 160) begin : g_addr_shift
      assign w_wr_addr = (16'(w_wy) << 7) + (16'(w_wy) << 5) + 16'(w_wx);
    end else begin : g_addr_mul
      assign w_wr_addr = 16'(w_wy) * 16'(H_PIXELS) + 16'(w_wx);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (w_we) begin
      r_mem[w_wr_addr[c_MW-1:0]] <= pix_color;
    end
  end

  // Non-blocking read of the array gives read-before-write on a collision.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_vga_data <= '0;
    end else if (vga_addr < 16'(c_DEPTH)) begin
      r_vga_data <= r_mem[vga_addr[c_MW-1:0]];
    end else begin
      r_vga_data <= '0;
    end
  end

  assign vga_data   = r_vga_data;
  assign frame_done = r_frame_done;
  assign overflow   = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_tia_framebuffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_tia_framebuffer: randomized scoreboard bench for tia_framebuffer        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_tia_framebuffer;

  localparam int H     = 160;
  localparam int V     = 240;
  localparam int SK    = 37;
  localparam int DEPTH = H * V;

  logic        clk, reset, pix_valid, line_start, frame_start;
  logic [6:0]  pix_color, vga_data;
  logic [15:0] vga_addr;
  logic        frame_done, overflow;

  tia_framebuffer #(.H_PIXELS(H), .V_LINES(V), .V_SKIP(SK)) dut (
    .clk(clk), .reset(reset), .pix_valid(pix_valid), .pix_color(pix_color),
    .line_start(line_start), .frame_start(frame_start), .vga_addr(vga_addr),
    .vga_data(vga_data), .frame_done(frame_done), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit         rd;
    bit         known;
    logic [6:0] data;
    bit         fd;
    bit         ovf;
  } exp_t;

  exp_t q[$];
  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: a frame is a count of line_starts since frame_start;
  // stored row = lines - SK while inside [SK, SK+V).
  bit       m_in_frame = 0;
  int       m_lines = 0;
  int       m_x = 0;
  bit       m_ovf = 0;
  bit [6:0] m_mem [DEPTH];
  bit       m_wr  [DEPTH];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc(input bit rs, input bit fs, input bit ls, input bit pv,
                     input logic [6:0] col, input bit rd, input logic [15:0] a);
    exp_t e;
    int   idx;
    reset = rs; frame_start = fs; line_start = ls; pix_valid = pv;
    pix_color = col; vga_addr = a;
    e.rd = rd;
    if (rs || int'(a) >= DEPTH) begin
      e.known = 1; e.data = 7'h0;
    end else begin
      e.known = m_wr[int'(a)]; e.data = m_mem[int'(a)];
    end
    e.fd = 0;
    if (rs) begin
      m_in_frame = 0; m_ovf = 0;
    end else if (fs) begin
      m_in_frame = 1; m_lines = 0; m_x = 0; m_ovf = 0;
    end else if (m_in_frame) begin
      if (ls && m_lines < SK + V) begin
        m_lines++; m_x = 0;
        e.fd = (m_lines == SK + V);
      end
      if (pv && m_lines >= SK && m_lines < SK + V) begin
        if (m_x < H) begin
          idx = (m_lines - SK) * H + m_x;
          m_mem[idx] = col; m_wr[idx] = 1; m_x++;
        end else begin
          m_ovf = 1;
        end
      end
    end
    e.ovf = m_ovf;
    q.push_back(e);
    @(negedge clk);
  endtask

  task automatic step(input bit fs, input bit ls, input bit pv, input logic [6:0] col);
    bit          rd;
    logic [15:0] a;
    rd = ($urandom_range(0, 2) == 0);
    case ($urandom_range(0, 9))
      0:       a = 16'($urandom_range(DEPTH, 65535));
      1, 2:    a = 16'($urandom_range(0, DEPTH - 1));
      default: a = 16'($urandom_range(0, 1599));
    endcase
    cyc(0, fs, ls, pv, col, rd, a);
  endtask

  task automatic rd_at(input int a);
    cyc(0, 0, 0, 0, 7'h0, 1, 16'(a));
  endtask

  task automatic pixels(input int n, input bit seq);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 3) == 0) step(0, 0, 0, 7'h0);
      step(0, 0, 1, seq ? 7'(i) : 7'($urandom));
    end
  endtask

  task automatic skip_lines(input int n);
    for (int k = 0; k < n; k++) begin
      repeat ($urandom_range(0, 3)) step(0, 0, 1'($urandom_range(0, 1)), 7'($urandom));
      step(0, 1, 0, 7'h0);
    end
  endtask

  task automatic body_lines(input int maxpix, input int ovf_line);
    for (int l = 1; l <= V; l++) begin
      step(0, 1, ($urandom_range(0, 3) == 0), 7'($urandom));
      pixels((l == ovf_line) ? 170 : $urandom_range(0, maxpix), 0);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        if (e.rd && e.known) chk("vga_data", 32'(vga_data), 32'(e.data));
        chk("frame_done", 32'(frame_done), 32'(e.fd));
        chk("overflow", 32'(overflow), 32'(e.ovf));
      end
    end
  end

  initial begin : stim
    repeat (3) cyc(1, 0, 0, 0, 7'h0, 1, 16'd0);
    repeat (20) step(0, ($urandom_range(0, 4) == 0), 1'($urandom_range(0, 1)), 7'($urandom));

    // Frame 1: full frame, line 0 sequential colours, one overflowing line.
    step(1, 0, 0, 7'h0);
    skip_lines(SK);
    pixels(H, 1);
    for (int a = 0; a < H; a++) rd_at(a);
    body_lines(12, 3);
    repeat (30) step(0, ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)), 7'($urandom));
    for (int a = 0; a < H; a++) rd_at(a);

    // Frame 2: frame_start+line_start together, read-before-write, overflow.
    step(1, 1, 1, 7'h11);
    skip_lines(SK - 1);
    step(0, 1, 1, 7'h0);
    for (int i = 1; i < 5; i++) step(0, 0, 1, 7'(i + 40));
    cyc(0, 0, 0, 1, 7'h55, 1, 16'd5);
    rd_at(5);
    rd_at(DEPTH);
    pixels(164, 0);
    step(0, 1, 0, 7'h0);
    repeat (3) step(0, 0, 0, 7'h0);
    rd_at(160);
    rd_at(161);

    // Abort with frame_start, then reset mid-frame.
    step(1, 0, 0, 7'h0);
    skip_lines(SK);
    pixels(20, 0);
    step(0, 1, 1, 7'($urandom));
    pixels(5, 0);
    cyc(1, 0, 1, 1, 7'h7f, 1, 16'd0);
    cyc(1, 0, 0, 1, 7'h7f, 1, 16'd0);
    repeat (20) step(0, ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), 7'($urandom));
    rd_at(0);
    rd_at(1);

    // Frame 3: short lines to completion, then restart from DONE.
    step(1, 0, 0, 7'h0);
    skip_lines(SK);
    pixels(10, 0);
    body_lines(3, 0);
    repeat (10) step(0, 0, 1, 7'($urandom));
    step(1, 0, 0, 7'h0);
    skip_lines(SK);
    pixels(30, 0);
    for (int a = 0; a < 1600; a++) rd_at(a);
    rd_at(65535);

    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    #2;
    if (q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/tia_framebuffer.md
TIA_FRAMEBUFFER -- requirements
Module: tia_framebuffer

Interface
REQ-001 Parameter H_PIXELS, default 160, visible pixels per stored line.
REQ-002 Parameter V_LINES, default 240, stored lines per frame.
REQ-003 Parameter V_SKIP, default 37, lines discarded after each frame_start before line 0 is stored.
REQ-004 clk  input  1  single system clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 pix_valid  input  1  one TIA colour clock carries a pixel this cycle.
REQ-007 pix_color  input  7  palette index of the pixel, valid when pix_valid=1.
REQ-008 line_start  input  1  single-cycle strobe marking the start of a TIA scanline.
REQ-009 frame_start  input  1  single-cycle strobe marking the start of a TIA frame (VSYNC end).
REQ-010 vga_addr  input  16  read address from the display stage, equal to y*160+x.
REQ-011 vga_data  output  7  palette index read from vga_addr, registered.
REQ-012 frame_done  output  1  one-cycle pulse when the last stored line of a frame completes.
REQ-013 overflow  output  1  sticky flag: a visible pixel arrived with x >= H_PIXELS.

Function
REQ-014 Storage: H_PIXELS*V_LINES entries (38400 by default), each 7 bits wide, with one write port and one read port, both on clk.
REQ-015 State machine: states WAIT_FRAME, SKIP, ACTIVE, DONE; the block enters WAIT_FRAME after reset.
REQ-016 WAIT_FRAME: all pixels are ignored; frame_start -> SKIP, with line_cnt=0.
REQ-017 SKIP: each line_start increments line_cnt; the line_start that makes line_cnt equal V_SKIP -> ACTIVE, with y=0 and x=0.
REQ-018 ACTIVE: pix_valid with x<H_PIXELS writes pix_color to address y*H_PIXELS+x, then x increments.
REQ-019 ACTIVE: pix_valid with x>=H_PIXELS causes no write and sets overflow; x saturates at H_PIXELS.
REQ-020 ACTIVE: line_start sets x=0 and increments y.
REQ-021 ACTIVE: the line_start that would make y equal V_LINES -> DONE and pulses frame_done for exactly one cycle.
REQ-022 DONE: all pixels are ignored; frame_start -> SKIP.
REQ-023 frame_start in any state -> SKIP with line_cnt=0, x=0, y=0; this aborts a partial frame, and no frame_done is issued for it.
REQ-024 Simultaneous frame_start and line_start: frame_start wins, and line_start is ignored that cycle.
REQ-025 pix_valid in the same cycle as line_start (ACTIVE): the pixel is written to x=0 of the new line, i.e. new y, and x becomes 1.
REQ-026 The write address is computed as y*160+x using only shifts and adds: (y<<7)+(y<<5)+x; the result is 16 bits wide, and no multiplier is inferred.
REQ-027 Read latency: vga_data reflects the entry at vga_addr sampled one clk edge earlier.
REQ-028 Read of an address >= H_PIXELS*V_LINES returns 0.
REQ-029 Read and write to the same address in the same cycle: vga_data returns the old contents (read-before-write).
REQ-030 overflow clears only on reset or on frame_start.

Reset
REQ-031 While reset=1, the block is in WAIT_FRAME, x=y=line_cnt=0, vga_data=0, frame_done=0, overflow=0.
REQ-032 Storage contents are not cleared by reset.
REQ-033 Reset asserted mid-frame abandons the frame immediately, with no further writes and no frame_done.
REQ-034 After reset deassertion, no write occurs until a frame_start is followed by V_SKIP line_starts.

Verification
REQ-035 Reset release, then pixels with no frame_start -> no writes occur, and reading addr 0 returns the prior contents.
REQ-036 frame_start, 37 line_starts, 160 pixels with colors 0..127 wrapping -> addr 0..159 hold the same sequence, and vga_data lags vga_addr by 1 cycle.
REQ-037 Full frame of 240 lines -> frame_done pulses once, in the cycle after line_start #277 following frame_start; later pixels cause no writes.
REQ-038 Line with 170 pixels -> addr 160 (line 1, x=0) is unchanged and overflow=1; a following frame_start clears overflow.
REQ-039 frame_start and line_start asserted in the same cycle -> line_cnt=0 after the edge; a pixel arriving with line_start writes to x=0 of the new line.
REQ-040 Write 7'h55 to addr 5 while reading addr 5 in the same cycle -> vga_data shows the old value, then 7'h55 on the next read; a read of addr 38400 returns 0.
